// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction memory.
// It takes a program as a byte stream, high byte first, and writes it as
// INST_W-bit words to addresses 0..count-1. A trailing checksum byte, the XOR
// of all data bytes, follows the data. cpu_reset holds the processor in reset
// during the load. It is released only after a load whose checksum matches.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_ni     asynchronous active-low reset
//   start_i      1-cycle pulse that starts a load (ignored while busy)
//   count_i      number of words to load, sampled on start (saturates at 2**ADDR_W)
//   rx_valid_i   byte source has rx_data_i
//   rx_data_i    stream byte
//   rx_ready_o   loader accepts a byte (transfer on rx_valid_i && rx_ready_o)
//   wr_en_o      instruction memory write strobe, one cycle per word
//   wr_addr_o    write address
//   wr_data_o    write data
//   cpu_reset_o  active-high reset to the PC/counter
//   busy_o       load in progress
//   done_o       1-cycle pulse at the end of a load
//   err_o        checksum mismatch on the last load, sticky until next start
//
// state | meaning
// IDLE  | waiting for start
// HI    | waiting for the high byte of a word
// LO    | waiting for the low byte of a word
// WR    | write strobe for the assembled word
// CHK   | waiting for the checksum byte
// DONE  | done pulse, cpu_reset follows the checksum result
module prog_loader #(
  parameter int ADDR_W = 11,
  parameter int INST_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [INST_W-1:0] wr_data_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [7:0]          xor_q;
  logic                rx_ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [INST_W-1:0]   wr_data_q;
  logic                cpu_reset_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [ADDR_W:0]     cnt_sat_d;
  logic [ADDR_W:0]     addr_next_d;
  logic                xfer;

  assign cnt_sat_d   = (count_i > MAX_CNT) ? MAX_CNT : count_i;
  // One bit wider than the address, so it can compare against a full count.
  assign addr_next_d = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign xfer        = rx_valid_i && rx_ready_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      xor_q       <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q       <= cnt_sat_d;
            wr_addr_q   <= '0;
            xor_q       <= '0;
            err_q       <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            rx_ready_q  <= 1'b1;
            state_q     <= (cnt_sat_d == '0) ? CHK : HI;
          end
        end
        HI: begin
          if (xfer) begin
            wr_data_q[INST_W-1 -: 8] <= rx_data_i;
            xor_q                    <= xor_q ^ rx_data_i;
            state_q                  <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            wr_data_q[7:0] <= rx_data_i;
            xor_q          <= xor_q ^ rx_data_i;
            rx_ready_q     <= 1'b0;
            wr_en_q        <= 1'b1;
            state_q        <= WR;
          end
        end
        WR: begin
          rx_ready_q <= 1'b1;
          // The address is held on the last word so a full-size load does not wrap to 0.
          if (addr_next_d == cnt_q) begin
            state_q <= CHK;
          end else begin
            wr_addr_q <= addr_next_d[ADDR_W-1:0];
            state_q   <= HI;
          end
        end
        CHK: begin
          if (xfer) begin
            err_q      <= (rx_data_i != xor_q);
            rx_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          cpu_reset_q <= err_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
